riscv_imem_loader: RTL and testbench
====================================

// Module: riscv_imem_loader
// PURPOSE
//   Boot-time sequencer for the single-cycle riscv core. Holds the core in reset while it
//   streams instruction words from a valid/ready source into the instruction memory write
//   port (we/addr/data). Waits a fixed settle time after the last word, then releases the core.
//   Sits between the host/UART front end and riscv (Instr_Mem write port, core rst_n).
// PARAMETERS
//   ADDR_W    8   instruction memory word-address width; DEPTH = 2**ADDR_W words
//   HOLD_CYC  4   cycles the core stays in reset after the final write (1..255)
// PORTS
//   clk          in   1       system clock, all logic on posedge
//   rst          in   1       asynchronous active-high reset
//   start        in   1       pulse: begin a new load (ignored in LOAD/HOLD)
//   src_valid    in   1       source word valid
//   src_data     in   32      instruction word, little-endian RV32 encoding
//   src_last     in   1       marks final word of the image, qualified by src_valid
//   src_ready    out  1       loader accepts src_data this cycle
//   imem_we      out  1       instruction memory write enable
//   imem_waddr   out  ADDR_W  word address (byte address >> 2)
//   imem_wdata   out  32      write data
//   core_rst_n   out  1       active-low reset to the riscv core
//   done         out  1       image loaded, core running
//   error        out  1       load aborted (overflow, or checksum mismatch)
// BEHAVIOUR
//   - Reset values: src_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst_n=0,
//     done=0, error=0, state=IDLE, word counter=0, hold counter=0.
//   - States: IDLE, LOAD, HOLD, RUN, ERR.
//   - IDLE: core held. start=1 -> LOAD. src_valid is ignored (src_ready=0).
//   - LOAD: src_ready=1. A word is accepted when src_valid&&src_ready.
//     Write is registered: accept in cycle N -> imem_we=1 in cycle N+1 with
//     imem_waddr = counter value at accept and imem_wdata = accepted word. The counter
//     increments on accept. imem_we is otherwise 0. Throughput: 1 word/cycle.
//   - Accept with src_last=1 -> HOLD on the next cycle, with src_ready=0.
//   - Overflow: a word accepted at address DEPTH-1 with src_last=0 -> ERR. That word
//     is still written. There is no wrap-around to address 0.
//   - HOLD: counts HOLD_CYC cycles, then -> RUN. The first HOLD cycle coincides with the
//     final imem_we pulse.
//   - RUN: core_rst_n=1, done=1. start=1 -> LOAD next cycle. core_rst_n=0 and done=0
//     in that same next cycle. The counter clears to 0.
//   - ERR: error=1 (sticky), core_rst_n=0, src_ready=0. start=1 -> LOAD, which clears
//     error and the counter.
//   - start in LOAD/HOLD is ignored. start and src_valid in the same IDLE cycle: start
//     wins and no word is taken.
//   - Async rst mid-load: all outputs return to reset values immediately and the core is
//     held. Memory contents are not cleared. An in-flight write is dropped.
//   - The counter is ADDR_W+1 bits wide so that the DEPTH boundary is detectable.
// CONFIGURATION
//   RISCV_IMEM_CHECKSUM_EN defined:
//     - The src_last word is a checksum and is not written to memory.
//     - The loader keeps a 32-bit running sum (mod 2^32) of all written words.
//     - sum == checksum -> HOLD. Mismatch -> ERR.
//     - An image with only a checksum word (sum 0) is legal.
//   Not defined:
//     - The src_last word is an ordinary instruction and is written.
//     - No summing logic is built.
// TESTING
//   1. rst high 3 cyc, release -> all outputs at reset values; core_rst_n=0 until load done.
//   2. start, stream 0x00500093,0x00300113,0x002081B3(last) back-to-back ->
//      we at addr 0,1,2 in consecutive cycles; done=1 and core_rst_n=1 exactly HOLD_CYC
//      cycles after the last write.
//   3. ADDR_W=2, send 5 words without last -> 4 writes (addr 0..3), error=1,
//      src_ready=0, no 5th write.
//   4. src_valid toggling every other cycle -> writes only on accepted words; addresses
//      contiguous with no gaps.
//   5. Assert rst after 2 of 3 words -> immediate reset values; restart reloads from
//      addr 0.
//   6. CHECKSUM_EN: words 1,2 + checksum 3 -> RUN with 2 writes; checksum 4 -> error=1,
//      core held.

Source files
------------

// File: rtl/riscv_imem_loader.sv
// riscv_imem_loader
//   Boot-time sequencer for the single-cycle riscv core. It holds the core in
//   reset and streams instruction words from a valid/ready source into the
//   instruction memory write port. After the final word it waits HOLD_CYC
//   cycles and then releases the core.
//
//   Optional feature: define RISCV_IMEM_CHECKSUM_EN to treat the src_last word
//   as a 32-bit checksum of all written words. That word is then not written.
//   A matching sum proceeds to the hold phase; a mismatch aborts with error.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         asynchronous active-high reset
//   start       pulse, begins a new load (ignored while loading/holding)
//   src_valid   source word valid
//   src_data    32-bit instruction word
//   src_last    final word of the image, qualified by src_valid
//   src_ready   loader accepts src_data this cycle
//   imem_we     instruction memory write enable
//   imem_waddr  instruction memory word address
//   imem_wdata  instruction memory write data
//   core_rst_n  active-low reset to the riscv core
//   done        image loaded, core running
//   error       load aborted (overflow or checksum mismatch), sticky
module riscv_imem_loader #(
  parameter int ADDR_W   = 8,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_valid,
  input  logic [31:0]       src_data,
  input  logic              src_last,
  output logic              src_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error
);

  // Highest legal word address; the counter carries one extra bit so that
  // reaching DEPTH is visible instead of silently wrapping to 0.
  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [7:0]      HOLD_LAST = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [ADDR_W:0] wcnt;
  logic [7:0]      hold_cnt;
  logic            acc_p0;
  logic            wr_p0;
  logic            load_go;

  assign acc_p0  = (state == S_LOAD) && src_valid;
  assign load_go = (state_n == S_LOAD) && (state != S_LOAD);

`ifdef RISCV_IMEM_CHECKSUM_EN
  logic [31:0] sum;
  logic        ck_ok;

  // The checksum word itself is never written to memory.
  assign wr_p0 = acc_p0 && !src_last;
  assign ck_ok = (sum == src_data);
`else
  assign wr_p0 = acc_p0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    src_ready  = 1'b0;
    core_rst_n = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_LOAD;
      end
      S_LOAD: begin
        src_ready = 1'b1;
        if (acc_p0) begin
          if (src_last) begin
`ifdef RISCV_IMEM_CHECKSUM_EN
            state_n = ck_ok ? S_HOLD : S_ERR;
`else
            state_n = S_HOLD;
`endif
          end else if (wcnt == LAST_ADDR) begin
            // Memory full and the image has not ended: abort.
            state_n = S_ERR;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_n = S_RUN;
      end
      S_RUN: begin
        core_rst_n = 1'b1;
        done       = 1'b1;
        if (start) state_n = S_LOAD;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_n = S_LOAD;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Stage 0 -> 1: accepted word becomes a registered memory write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= wr_p0;
      if (wr_p0) begin
        imem_waddr <= wcnt[ADDR_W-1:0];
        imem_wdata <= src_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (load_go) begin
      wcnt <= '0;
    end else if (wr_p0) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  // The first HOLD cycle is the one carrying the final write pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == S_HOLD) begin
      hold_cnt <= hold_cnt + 8'd1;
    end else begin
      hold_cnt <= '0;
    end
  end

`ifdef RISCV_IMEM_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (load_go) begin
      sum <= '0;
    end else if (wr_p0) begin
      sum <= sum + src_data;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Testbench for riscv_imem_loader: behavioural model plus directed and
// randomized stimulus. Uses a small memory (ADDR_W=2) so the overflow
// boundary is reachable quickly.
module tb_riscv_imem_loader;
  localparam int ADDR_W   = 2;
  localparam int HOLD_CYC = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              src_valid = 1'b0;
  logic [31:0]       src_data = '0;
  logic              src_last = 1'b0;
  logic              src_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              error;

  riscv_imem_loader #(.ADDR_W(ADDR_W), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .src_valid(src_valid),
    .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Behavioural model: what the loader is doing, in plain terms.
  bit          m_load;
  bit          m_run;
  bit          m_err;
  int          m_hold;   // cycles of reset-hold still to go
  int          m_next;   // next word address
  logic [31:0] m_sum;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_data;

  // Observed write / done events for directed checks.
  int          wr_cyc[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cyc = -1;
  bit          prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    m_we = 1'b0;
    if (rst) begin
      m_load = 0; m_run = 0; m_err = 0; m_hold = 0;
      m_next = 0; m_sum = '0; m_addr = 0; m_data = '0;
      return;
    end
    if (m_load) begin
      if (src_valid) begin
`ifdef RISCV_IMEM_CHECKSUM_EN
        if (src_last) begin
          m_load = 0;
          if (m_sum == src_data) m_hold = HOLD_CYC;
          else m_err = 1;
          return;
        end
`endif
        m_we = 1; m_addr = m_next; m_data = src_data;
        m_sum = m_sum + src_data;
        m_next++;
        if (src_last) begin
          m_load = 0; m_hold = HOLD_CYC;
        end else if (m_next == DEPTH) begin
          m_load = 0; m_err = 1;
        end
      end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_run = 1;
    end else if (start) begin
      m_load = 1; m_run = 0; m_err = 0; m_next = 0; m_sum = '0;
    end
  endtask

  // Compare process: one model step per clock edge, outputs sampled 1 unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      chk("src_ready", src_ready, m_load);
      chk("imem_we", imem_we, m_we);
      chk("core_rst_n", core_rst_n, m_run);
      chk("done", done, m_run);
      chk("error", error, m_err);
      if (m_we || rst) begin
        chk("imem_waddr", imem_waddr, m_addr);
        chk("imem_wdata", imem_wdata, m_data);
      end
      if (imem_we) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(imem_waddr));
        wr_data.push_back(imem_wdata);
      end
      if (done && !prev_done) done_cyc = cyc;
      prev_done = done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit st, input bit v, input logic [31:0] d, input bit l);
    @(negedge clk);
    start = st; src_valid = v; src_data = d; src_last = l;
  endtask

  task automatic clear_log();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    done_cyc = -1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_waddr"}, imem_waddr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_core_rst_n"}, core_rst_n, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic wait_settle(input string tag, input int maxc);
    int n = 0;
    while (!(done || error) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_settle_timeout"}, done || error, 1);
  endtask

  logic [31:0] t2w[3];
  logic [31:0] w[3];
  int          nexp;

  initial begin
    t2w[0] = 32'h00500093; t2w[1] = 32'h00300113; t2w[2] = 32'h002081B3;

    // Reset held for three cycles, then released.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals("rst_rel");
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("idle_core_held", core_rst_n, 0);

    // Back-to-back three-word image.
    clear_log();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, t2w[i], i == 2);
    drive(0, 0, 0, 0);
    wait_settle("t2", 40);
`ifdef RISCV_IMEM_CHECKSUM_EN
    chk("t2_nwr", wr_addr.size(), 2);
    chk("t2_error", error, 1);
    chk("t2_core_held", core_rst_n, 0);
`else
    chk("t2_nwr", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t2_addr", wr_addr[i], i);
        chk("t2_data", wr_data[i], t2w[i]);
      end
      chk("t2_consec1", wr_cyc[1] - wr_cyc[0], 1);
      chk("t2_consec2", wr_cyc[2] - wr_cyc[0], 2);
      chk("t2_done_lat", done_cyc - wr_cyc[2], HOLD_CYC);
    end
    chk("t2_done", done, 1);
    chk("t2_core_run", core_rst_n, 1);
`endif

    // Overflow: five words without last into a four-word memory.
    clear_log();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 32'h1000 + i, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("t3_nwr", wr_addr.size(), 4);
    for (int i = 0; i < wr_addr.size(); i++) chk("t3_addr", wr_addr[i], i);
    chk("t3_error", error, 1);
    chk("t3_src_ready", src_ready, 0);
    chk("t3_core_held", core_rst_n, 0);

    // src_valid every other cycle.
    clear_log();
    for (int i = 0; i < 3; i++) w[i] = $urandom;
`ifdef RISCV_IMEM_CHECKSUM_EN
    w[2] = w[0] + w[1];
    nexp = 2;
`else
    nexp = 3;
`endif
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, w[i], i == 2);
      if (i < 2) drive(0, 0, $urandom, 1'($urandom_range(0, 1)));
    end
    drive(0, 0, 0, 0);
    wait_settle("t4", 40);
    chk("t4_nwr", wr_addr.size(), nexp);
    for (int i = 0; i < wr_addr.size(); i++) begin
      chk("t4_addr", wr_addr[i], i);
      chk("t4_data", wr_data[i], w[i]);
      if (i > 0) chk("t4_gap", wr_cyc[i] - wr_cyc[i-1], 2);
    end
    chk("t4_done", done, 1);

    // Async reset after two of three words, then reload.
    clear_log();
    drive(1, 0, 0, 0);
    drive(0, 1, 32'hAAAA0001, 0);
    drive(0, 1, 32'hAAAA0002, 0);
    @(negedge clk);
    rst = 1'b1; src_valid = 1'b0; src_last = 1'b0;
    #1;
    check_reset_vals("t5_midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
    drive(1, 0, 0, 0);
    drive(0, 1, 32'hBBBB0001, 0);
    drive(0, 1, 32'hBBBB0002, 0);
    drive(0, 1, 32'hBBBB0003, 1);
    drive(0, 0, 0, 0);
    wait_settle("t5", 40);
    chk("t5_restart_nwr_ge1", wr_addr.size() >= 1, 1);
    if (wr_addr.size() >= 1) begin
      chk("t5_restart_addr0", wr_addr[0], 0);
      chk("t5_restart_data0", wr_data[0], 32'hBBBB0001);
    end

`ifdef RISCV_IMEM_CHECKSUM_EN
    // Checksum match, mismatch, and checksum-only image.
    clear_log();
    drive(1, 0, 0, 0);
    drive(0, 1, 32'd1, 0); drive(0, 1, 32'd2, 0); drive(0, 1, 32'd3, 1);
    drive(0, 0, 0, 0);
    wait_settle("t6a", 40);
    chk("t6a_nwr", wr_addr.size(), 2);
    chk("t6a_done", done, 1);
    chk("t6a_core_run", core_rst_n, 1);
    clear_log();
    drive(1, 0, 0, 0);
    drive(0, 1, 32'd1, 0); drive(0, 1, 32'd2, 0); drive(0, 1, 32'd4, 1);
    drive(0, 0, 0, 0);
    wait_settle("t6b", 40);
    chk("t6b_error", error, 1);
    chk("t6b_core_held", core_rst_n, 0);
    clear_log();
    drive(1, 0, 0, 0);
    drive(0, 1, 32'd0, 1);
    drive(0, 0, 0, 0);
    wait_settle("t6c", 40);
    chk("t6c_nwr", wr_addr.size(), 0);
    chk("t6c_done", done, 1);
`endif

    // Randomized traffic, including stray starts and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 5) == 0);
      src_valid = ($urandom_range(0, 3) != 0);
      src_last  = ($urandom_range(0, 3) == 0);
      src_data  = $urandom;
`ifdef RISCV_IMEM_CHECKSUM_EN
      if (src_last && $urandom_range(0, 1) == 1) src_data = m_sum;
`endif
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; src_valid = 1'b0; src_last = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
